// File: rtl/date_down_counter_pkg.sv
// Shared types and constants for the calendar day/month down-counter.
// Month-length constants and month identifiers live here so the lookup and the top agree.
package date_down_counter_pkg;

  localparam int DATE_W_DEF = 6;

  typedef logic [DATE_W_DEF-1:0] date_t;
  typedef logic [3:0]            month_t;

  localparam int LEN_31 = 31;
  localparam int LEN_30 = 30;
  localparam int LEN_28 = 28;
  localparam int LEN_29 = 29;

  localparam month_t MONTH_JAN = 4'd1;
  localparam month_t MONTH_FEB = 4'd2;
  localparam month_t MONTH_DEC = 4'd12;

  // Previous calendar month; January wraps to the last month of the year.
  function automatic month_t prev_month(input month_t m, input month_t last);
    if (m == MONTH_JAN) begin
      return last;
    end
    return m - 4'd1;
  endfunction

endpackage

// File: rtl/date_down_counter_month_length.sv
// Combinational month-to-day-count lookup; leap selects a 29-day February.
module date_down_counter_month_length
  import date_down_counter_pkg::*;
#(
  parameter int DATE_W = 6
) (
  input  month_t            month,
  input  logic              leap,
  output logic [DATE_W-1:0] days
);

  always_comb begin
    days = DATE_W'(LEN_31);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = DATE_W'(LEN_30);
      MONTH_FEB:               days = leap ? DATE_W'(LEN_29) : DATE_W'(LEN_28);
      default:                 days = DATE_W'(LEN_31);
    endcase
  end

endmodule

// File: rtl/date_down_counter.sv
// Day-of-month/month down-counter with registered borrow pulses on month and year wrap.
// Optional LEAP_YEAR_EN adds a 2-bit leap phase (0 = leap year) stepped back on each year wrap.
module date_down_counter
  import date_down_counter_pkg::*;
#(
  parameter int MONTHS = 12,
  parameter int DATE_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DATE_W-1:0] load_date,
  input  logic [3:0]        load_month,
  output logic [DATE_W-1:0] date,
  output logic [3:0]        month,
  output logic              borrow,
  output logic              month_borrow
);

  localparam month_t            MONTH_LAST = month_t'(MONTHS);
  localparam logic [DATE_W-1:0] DATE_ONE   = DATE_W'(1);

  logic              leap;
  logic              wrap;
  logic              year_wrap;
  month_t            wrap_month;
  month_t            load_month_c;
  logic [DATE_W-1:0] wrap_len;
  logic [DATE_W-1:0] load_len;
  logic [DATE_W-1:0] load_date_c;
  logic [DATE_W-1:0] date_nxt;
  month_t            month_nxt;

  // A wrap only happens on a real decrement: load takes priority over en.
  assign wrap      = en && !load && (date == DATE_ONE);
  assign year_wrap = wrap && (month == MONTH_JAN);

`ifdef LEAP_YEAR_EN
  logic [1:0] leap_phase;

  always_ff @(posedge clk) begin
    if (!rst) begin
      leap_phase <= 2'd0;
    end else if (year_wrap) begin
      leap_phase <= leap_phase + 2'd3;
    end
  end

  assign leap = (leap_phase == 2'd0);
`else
  assign leap = 1'b0;
`endif

  always_comb begin
    wrap_month   = prev_month(month, MONTH_LAST);
    load_month_c = load_month;
    if (load_month == 4'd0 || load_month > MONTH_LAST) begin
      load_month_c = MONTH_JAN;
    end
  end

  date_down_counter_month_length #(.DATE_W(DATE_W)) u_len_wrap (
    .month (wrap_month),
    .leap  (leap),
    .days  (wrap_len)
  );

  date_down_counter_month_length #(.DATE_W(DATE_W)) u_len_load (
    .month (load_month_c),
    .leap  (leap),
    .days  (load_len)
  );

  // Loaded date is clamped against the clamped month's length.
  always_comb begin
    load_date_c = load_date;
    if (load_date == '0) begin
      load_date_c = DATE_ONE;
    end else if (load_date > load_len) begin
      load_date_c = load_len;
    end
  end

  always_comb begin
    date_nxt  = date;
    month_nxt = month;
    if (load) begin
      date_nxt  = load_date_c;
      month_nxt = load_month_c;
    end else if (en) begin
      if (wrap) begin
        date_nxt  = wrap_len;
        month_nxt = wrap_month;
      end else begin
        date_nxt  = date - DATE_ONE;
      end
    end
  end

  // Pulses are re-evaluated every edge, so they never outlast one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      date         <= DATE_ONE;
      month        <= MONTH_JAN;
      borrow       <= 1'b0;
      month_borrow <= 1'b0;
    end else begin
      date         <= date_nxt;
      month        <= month_nxt;
      borrow       <= wrap;
      month_borrow <= year_wrap;
    end
  end

endmodule

// File: doc/date_down_counter.md
# date_down_counter

Day-of-month/month down-counter for the clock/calendar datapath, the decrement counterpart of the incrementing day-of-month counter. It steps the calendar backwards one day per enable, reloads the previous month's last day on underflow, and emits registered borrow pulses. Set-mode logic uses it to drive the displayed date backwards, and it drives a downstream year/weekday logic chain through its borrow pulses.

## Interface
Parameters:
- MONTHS, 12, number of months; month field range is 1..MONTHS.
- DATE_W, 6, width of the date field, matching the incrementing day counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; synchronous and active-low.
- en  in  1  decrement request; one day per cycle while high.
- load  in  1  load date and month from the load inputs.
- load_date  in  DATE_W  date value captured when load is high.
- load_month  in  4  month value captured when load is high.
- date  out  DATE_W  current day of month, range 1..31.
- month  out  4  current month, range 1..12.
- borrow  out  1  one-cycle pulse when date wraps from 1 into the previous month.
- month_borrow  out  1  one-cycle pulse when the January 1 to December 31 wrap occurs.

## Operation
- Reset (rst low at a posedge):
  - date=1, month=1, borrow=0, month_borrow=0.
  - Leap phase=0 when LEAP_YEAR_EN is defined.
- Priority per edge: reset, then load, then en.
- Load:
  - month is set to load_month. A load_month of 0 or above 12 is clamped to 1.
  - date is then set to load_date. A load_date of 0 is clamped to 1.
  - A load_date above the loaded month's length is clamped to that length.
  - A load produces no borrow pulses.
- Decrement (en=1, load=0):
  - date>1: date=date-1.
  - date==1: month steps to the previous month (1 wraps to 12), date becomes the previous month's length, borrow=1.
  - If that wrap also took month from 1 to 12: month_borrow=1.
- Month length:
  - 31 days: months 1, 3, 5, 7, 8, 10, 12.
  - 30 days: months 4, 6, 9, 11.
  - 28 days: month 2, or 29 as described under Configuration.
- Pulses are registered outputs. They are cleared on every edge where no wrap occurs, so they can never stretch beyond one cycle, even with en held high.
- en low: all state holds and both pulses return to 0.

## Timing
- Decrement latency is one edge: the new date and month are visible the cycle after en is sampled.
- borrow and month_borrow are high in that same following cycle, coincident with the reloaded date.
- Continuous en steps one day per cycle. March 1 takes 1 cycle to reach Feb 28, and 28 more cycles to reach Jan 31.
- Simultaneous load and en: the load wins, the decrement is dropped, and no pulse is produced.
- Reset asserted mid-sequence overrides everything: the next cycle shows 1/1 with both pulses low, even if a wrap was due.
- A reset-state decrement (1/1, en=1) gives 12/31 with borrow=1 and month_borrow=1 on the next cycle.

## Configuration
- LEAP_YEAR_EN defined:
  - A 2-bit leap phase register is added; phase 0 denotes a leap year.
  - Each month_borrow event steps the phase to (phase+3) mod 4, i.e. one year back.
  - February length is 29 when phase==0, otherwise 28.
  - Loads do not alter the phase.
- LEAP_YEAR_EN undefined: February is always 28 and no phase register exists.

## Structure
- Shared package holds:
  - The month-length constants (31/30/28/29).
  - The constants MONTH_JAN, MONTH_FEB and MONTH_DEC.
  - A date_t typedef of DATE_W bits and a month_t typedef of 4 bits.
- Sub-module month_length: purely combinational month (and leap flag) to day-count lookup. It is instanced twice, once for the previous month on wrap and once for the load clamp.

## Test plan
- Reset, then en=1 for one cycle -> date=31, month=12, borrow=1, month_borrow=1 for one cycle; then both pulses return to 0.
- Load 3/1, en one cycle -> 2/28 with borrow=1, month_borrow=0 (28 regardless of macro, since leap phase is 3 after the prior year wrap). Separately, reset, load 3/1, en one cycle -> 2/29 with LEAP_YEAR_EN defined, 2/28 without.
- Load 5/1, en one cycle -> 4/30 with borrow=1. Continue en for 29 more cycles -> 4/1, with borrow staying 0 throughout.
- load_month=13, load_date=40 -> 1/31. load_month=4, load_date=0 -> 4/1. load_month=6, load_date=31 -> 6/30. No pulses in any of these cases.
- load and en high together at 7/1 -> 7/1 loaded, borrow=0.
- At 1/1 with en=1, rst low on the same edge -> next cycle 1/1 with both pulses 0; no 12/31 is ever seen.
